tt_uart_rx: RTL
===============

# tt_uart_rx

Serial receive front end inside the tiny RV32I TinyTapeout top. Consumes the raw `ui_in[0]` line the testbench drives, recovers 8N1 UART bytes with a mid-bit sampler, and buffers them in a small FIFO for the program loader / debug command decoder. Framing and overrun errors are reported as sticky flags.

## Interface
- `BAUD_DIV`, 434: clock cycles per bit (50 MHz / 115200); legal range ≥ 4.
- `FIFO_DEPTH`, 4: receive buffer entries; power of two, ≥ 2.
- `clk` in 1: system clock, the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx` in 1: raw serial line (`ui_in[0]`); idle high; asynchronous to `clk`.
- `rx_data` out 8: head-of-FIFO byte; valid only while `rx_valid`=1.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: consumer pop; a byte is popped on a cycle where `rx_valid & rx_ready`.
- `frame_err` out 1: sticky; stop bit sampled low.
- `overrun` out 1: sticky; byte arrived while FIFO full.
- `err_clr` in 1: synchronous clear of both sticky flags.

## Operation
- `rx` passes through a 2-FF synchronizer whose flops reset to 1; all decisions use the synchronized value `rxs`.
- Bit counter `bcnt` counts 0..BAUD_DIV-1. Bit index `bidx` counts 0..7.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on `rxs`=0, go to START with `bcnt` cleared.
  - START: at `bcnt` = BAUD_DIV/2 - 1 (integer division), sample `rxs`. If 1 (glitch), return to IDLE with no flag change. If 0, go to DATA with `bcnt` cleared and `bidx`=0.
  - DATA: at `bcnt` = BAUD_DIV-1, shift `rxs` into bit `bidx` (LSB first). After bit 7, go to STOP.
  - STOP: at `bcnt` = BAUD_DIV-1, sample `rxs`.
    - If 1: push the byte and go to IDLE.
    - If 0: set `frame_err`, discard the byte, and go to BREAK.
  - BREAK: stay until `rxs`=1, then go to IDLE. This prevents a held-low line from being decoded as repeated 0x00 bytes.
- FIFO: `FIFO_DEPTH` entries with `$clog2(FIFO_DEPTH)+1`-bit read and write pointers; wrap-around is by natural pointer overflow. Full when the pointer MSBs differ and the remaining bits are equal.
- Push while full and no pop in the same cycle: byte dropped, `overrun` set, FIFO contents unchanged.
- Push and pop in the same cycle while full: both occur; no overrun.
- Push and pop in the same cycle while empty: the push lands; the pop is ignored because `rx_valid` was 0.
- `err_clr` together with a new error event in the same cycle: the set wins.
- `rx_data` is the combinational read of the head entry (no output register).

## Timing
- Reset values:
  - FSM = IDLE; `bcnt`, `bidx` and the shift register = 0; synchronizer flops = 1.
  - Pointers = 0; `rx_valid`=0, `rx_data`=0, `frame_err`=0, `overrun`=0.
- Synchronizer latency: 2 cycles from a `rx` edge to `rxs`.
- The start bit's mid-sample occurs BAUD_DIV/2 cycles after `rxs` falls. Each data bit is sampled BAUD_DIV cycles after the previous sample.
- A byte becomes visible (`rx_valid`=1) one cycle after the stop-bit sample cycle.
- Back-to-back frames: IDLE is reached at the stop-bit mid-sample, so a start edge arriving half a bit later is caught.
- Pop: `rx_valid`/`rx_data` update the cycle after a pop handshake.
- Reset asserted mid-frame: everything returns to reset values immediately, FIFO contents are lost, and the partial byte is not pushed. After release, an in-progress low line is treated as a start bit.

## Structure
- Shared package `tt_pkg`:
  - Localparam for the state encoding (`RX_IDLE`…`RX_BREAK`, 3 bits).
  - Default `BAUD_DIV` constant, reused by the future TX block.
- One sub-module: `tt_sync_fifo` (parameterised width/depth; push, pop, full, empty). It is reused for TX later.
- The synchronizer, FSM and counters live in `tt_uart_rx`.

## Test plan
All scenarios run with BAUD_DIV=8 and FIFO_DEPTH=4.
- Reset mid-frame: assert `rst_n`=0 during DATA bit 3 -> all outputs 0 and no byte appears after release with the line held idle.
- Single frame: send 0xA5 -> `rx_valid` rises (2 + 4 + 9×8 + 1) cycles after the falling edge; `rx_data`=0xA5; flags stay 0.
- Glitch: drive `rx` low for 2 cycles -> FSM returns to IDLE, no byte, no flags.
- Framing error: send 0x3C with stop bit=0, then hold the line low for 40 cycles -> `frame_err`=1, FIFO empty, stays in BREAK; next valid frame 0x11 is then received. Pulsing `err_clr` clears `frame_err`.
- Overrun and wrap: send 0x01..0x05 with `rx_ready`=0 -> `overrun`=1 after byte 5; pops return 0x01..0x04. Then send 8 more bytes with `rx_ready`=1 -> pops arrive in order across pointer wrap.
- Simultaneous push/pop at full: hold 4 bytes and pulse `rx_ready` on the stop-sample push cycle -> no overrun, 4 entries remain, order preserved.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared definitions for the TinyTapeout RV32I serial blocks (RX now, TX later).
package tt_pkg;

   // 50 MHz core clock, 115200 baud
   localparam int BAUD_DIV_DEF = 434;

   // Receiver state encoding
   localparam logic [2:0] RX_IDLE  = 3'd0;
   localparam logic [2:0] RX_START = 3'd1;
   localparam logic [2:0] RX_DATA  = 3'd2;
   localparam logic [2:0] RX_STOP  = 3'd3;
   localparam logic [2:0] RX_BREAK = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = RX_IDLE,
      ST_START = RX_START,
      ST_DATA  = RX_DATA,
      ST_STOP  = RX_STOP,
      ST_BREAK = RX_BREAK
   } rx_state_e;

endpackage

// File: rtl/tt_uart_rx_if.sv
// Byte stream handshake from the UART receiver to its consumer (loader / debug decoder).
interface tt_uart_rx_if;
   logic [7:0] rx_data;   // head-of-FIFO byte, valid while rx_valid
   logic       rx_valid;  // FIFO not empty
   logic       rx_ready;  // consumer pop

   modport master (output rx_data, output rx_valid, input  rx_ready);
   modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

// File: rtl/tt_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module tt_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wp, rp;
   logic             do_push, do_pop;

   assign empty   = (wp == rp);
   assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rp[AW-1:0]];

   // Pointer and storage update; contents cleared on reset so rdata reads 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wp[AW-1:0]] <= wdata;
            wp              <= wp + 1'b1;
         end
         if (do_pop) rp <= rp + 1'b1;
      end
   end

endmodule

// File: rtl/tt_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling FSM, byte FIFO and
// sticky framing / overrun flags.
module tt_uart_rx
   import tt_pkg::*;
#(
   parameter int BAUD_DIV   = BAUD_DIV_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rx,
   input  logic            err_clr,
   tt_uart_rx_if.master    host,
   output logic            frame_err,
   output logic            overrun
);

   localparam int             BW    = $clog2(BAUD_DIV);
   localparam logic [BW-1:0]  BMAX  = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0]  BHALF = BW'(BAUD_DIV / 2 - 1);

   logic            sync1, rxs;
   rx_state_e       state;
   logic [BW-1:0]   bcnt;
   logic [2:0]      bidx;
   logic [7:0]      shreg;
   logic            stop_smp, push, pop, full, empty;

   // Two-flop synchronizer; idle-high reset so no false start after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rx;
         rxs   <= sync1;
      end
   end

   // Frame FSM with bit timer and bit index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         bcnt  <= '0;
         bidx  <= '0;
         shreg <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!rxs) begin
                  state <= ST_START;
                  bcnt  <= '0;
               end
            end
            ST_START: begin
               if (bcnt == BHALF) begin
                  // High at mid-start means a glitch, not a frame
                  if (rxs) state <= ST_IDLE;
                  else begin
                     state <= ST_DATA;
                     bcnt  <= '0;
                     bidx  <= '0;
                  end
               end else bcnt <= bcnt + 1'b1;
            end
            ST_DATA: begin
               if (bcnt == BMAX) begin
                  shreg[bidx] <= rxs;
                  bcnt        <= '0;
                  if (bidx == 3'd7) begin
                     state <= ST_STOP;
                     bidx  <= '0;
                  end else bidx <= bidx + 1'b1;
               end else bcnt <= bcnt + 1'b1;
            end
            ST_STOP: begin
               if (bcnt == BMAX) begin
                  // Back to IDLE at mid-stop so the next start edge is caught
                  bcnt  <= '0;
                  state <= rxs ? ST_IDLE : ST_BREAK;
               end else bcnt <= bcnt + 1'b1;
            end
            ST_BREAK: begin
               // Held-low line must return high before another frame
               if (rxs) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign stop_smp = (state == ST_STOP) && (bcnt == BMAX);
   assign push     = stop_smp && rxs;
   assign pop      = host.rx_ready && !empty;

   tt_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (shreg),
      .pop   (pop),
      .rdata (host.rx_data),
      .full  (full),
      .empty (empty)
   );

   assign host.rx_valid = !empty;

   // Sticky error flags; a new event wins over a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (stop_smp && !rxs)         frame_err <= 1'b1;
         else if (err_clr)             frame_err <= 1'b0;
         if (push && full && !pop)     overrun   <= 1'b1;
         else if (err_clr)             overrun   <= 1'b0;
      end
   end

endmodule
